// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants and state types for the UART command receiver.
// Command codes, ASCII terminators and receiver/parser FSM encodings.
package uart_cmd_rx_pkg;

  localparam logic [1:0] DC_PROCEED    = 2'b00;
  localparam logic [1:0] DC_TURN_LEFT  = 2'b01;
  localparam logic [1:0] DC_TURN_RIGHT = 2'b10;
  localparam logic [1:0] DC_STOP       = 2'b11;

  localparam logic FORWARDS = 1'b1;
  localparam logic REVERSE  = 1'b0;

  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;

  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_S = 8'h53;
  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] CH_B = 8'h42;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_WAIT,
    P_TERM,
    P_DISCARD
  } p_state_t;

endpackage

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, bit-period counter and receiver FSM.
// Emits rxByte/rxValid on a good stop bit, frameErr on a low stop bit.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1;
  logic             rx_s;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_clr;
  logic             take_bit;
  logic             stop_ok;
  logic             stop_bad;

  // Counter is cleared at the start midpoint so every later sample lands mid-bit.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    take_bit   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          cnt_clr    = 1'b1;
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_clr  = 1'b1;
          take_bit = 1'b1;
          if (bit_idx == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          state_next = RX_IDLE;
          stop_ok    = rx_s;
          stop_bad   = !rx_s;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rxByte   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      sync1    <= rxData;
      rx_s     <= sync1;
      state    <= state_next;
      cnt      <= cnt_clr ? '0 : cnt + CNT_W'(1);
      rxValid  <= stop_ok;
      frameErr <= stop_bad;
      if (state == RX_IDLE) bit_idx <= '0;
      if (take_bit) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_ok) rxByte <= shift;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: parses single-letter commands terminated by CR.
// Optional echo port to the TX buffer enabled by defining UART_RX_ECHO_EN.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       frameErr,
  output logic [1:0] dirCmd,
  output logic       dirValid,
  output logic       driveCmd,
  output logic       driveValid,
  output logic       cmdErr
`ifdef UART_RX_ECHO_EN
  ,
  output logic [7:0] echoDin,
  output logic       echoWrEn
`endif
);

  p_state_t   p_state;
  p_state_t   p_next;
  logic [7:0] cmd;
  logic [7:0] cmd_next;
  logic       commit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rxData  (rxData),
    .rxByte  (rxByte),
    .rxValid (rxValid),
    .frameErr(frameErr)
  );

  // cmdErr is combinational so a framing error reports in the same cycle.
  always_comb begin
    p_next   = p_state;
    cmd_next = cmd;
    cmdErr   = 1'b0;
    commit   = 1'b0;
    if (frameErr) begin
      if (p_state != P_DISCARD) cmdErr = 1'b1;
      p_next = P_DISCARD;
    end else if (rxValid) begin
      unique case (p_state)
        P_WAIT: begin
          case (rxByte)
            CH_P, CH_L, CH_R, CH_S, CH_F, CH_B: begin
              cmd_next = rxByte;
              p_next   = P_TERM;
            end
            ASCII_CR, ASCII_LF: p_next = P_WAIT;
            default: begin
              cmdErr = 1'b1;
              p_next = P_DISCARD;
            end
          endcase
        end
        P_TERM: begin
          if (rxByte == ASCII_CR) begin
            commit = 1'b1;
            p_next = P_WAIT;
          end else begin
            cmdErr = 1'b1;
            p_next = P_DISCARD;
          end
        end
        P_DISCARD: begin
          if (rxByte == ASCII_CR) p_next = P_WAIT;
        end
        default: p_next = P_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state    <= P_WAIT;
      cmd        <= '0;
      dirCmd     <= DC_STOP;
      dirValid   <= 1'b0;
      driveCmd   <= FORWARDS;
      driveValid <= 1'b0;
    end else begin
      p_state    <= p_next;
      cmd        <= cmd_next;
      dirValid   <= 1'b0;
      driveValid <= 1'b0;
      if (commit) begin
        case (cmd)
          CH_P: begin dirCmd <= DC_PROCEED;    dirValid <= 1'b1; end
          CH_L: begin dirCmd <= DC_TURN_LEFT;  dirValid <= 1'b1; end
          CH_R: begin dirCmd <= DC_TURN_RIGHT; dirValid <= 1'b1; end
          CH_S: begin dirCmd <= DC_STOP;       dirValid <= 1'b1; end
          CH_F: begin driveCmd <= FORWARDS;    driveValid <= 1'b1; end
          CH_B: begin driveCmd <= REVERSE;     driveValid <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_ECHO_EN
  assign echoDin  = rxByte;
  assign echoWrEn = rxValid;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed table-driven bench for uart_cmd_rx at 16 clocks per bit.
// Echo checks are compiled in when UART_RX_ECHO_EN is defined.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxData;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       frameErr;
  logic [1:0] dirCmd;
  logic       dirValid;
  logic       driveCmd;
  logic       driveValid;
  logic       cmdErr;
`ifdef UART_RX_ECHO_EN
  logic [7:0] echoDin;
  logic       echoWrEn;
  logic [7:0] echo_q[$];
`endif

  int compared   = 0;
  int mismatched = 0;

  int   rx_n = 0, ferr_n = 0, cerr_n = 0, dir_n = 0, drv_n = 0;
  logic both_seen = 1'b0;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxData    (rxData),
    .rxByte    (rxByte),
    .rxValid   (rxValid),
    .frameErr  (frameErr),
    .dirCmd    (dirCmd),
    .dirValid  (dirValid),
    .driveCmd  (driveCmd),
    .driveValid(driveValid),
    .cmdErr    (cmdErr)
`ifdef UART_RX_ECHO_EN
    ,
    .echoDin   (echoDin),
    .echoWrEn  (echoWrEn)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxValid)    rx_n++;
    if (frameErr)   ferr_n++;
    if (cmdErr)     cerr_n++;
    if (dirValid)   dir_n++;
    if (driveValid) drv_n++;
    if (dirValid && driveValid) both_seen = 1'b1;
`ifdef UART_RX_ECHO_EN
    if (echoWrEn) echo_q.push_back(echoDin);
`endif
  end

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         rx, ferr, cerr, dir, drv;
    logic [7:0] exp_byte;
    logic [1:0] exp_dc;
    logic       exp_dr;
  } vec_t;

  vec_t vec[30];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxData = frame[i];
      tick(CPB);
    end
    rxData = 1'b1;
    tick(GAP);
  endtask

  initial begin
    int s_rx, s_ferr, s_cerr, s_dir, s_drv;
    logic [9:0] pframe;

    // b stop  rx ferr cerr dir drv  byte  dirCmd driveCmd
    vec[0]  = '{8'h41, 1'b1, 1, 0, 1, 0, 0, 8'h41, 2'b11, 1'b1};
    vec[1]  = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b11, 1'b1};
    vec[2]  = '{8'h4C, 1'b1, 1, 0, 0, 0, 0, 8'h4C, 2'b11, 1'b1};
    vec[3]  = '{8'h0D, 1'b1, 1, 0, 0, 1, 0, 8'h0D, 2'b01, 1'b1};
    vec[4]  = '{8'h42, 1'b1, 1, 0, 0, 0, 0, 8'h42, 2'b01, 1'b1};
    vec[5]  = '{8'h0D, 1'b1, 1, 0, 0, 0, 1, 8'h0D, 2'b01, 1'b0};
    vec[6]  = '{8'h55, 1'b0, 0, 1, 1, 0, 0, 8'h0D, 2'b01, 1'b0};
    vec[7]  = '{8'h53, 1'b1, 1, 0, 0, 0, 0, 8'h53, 2'b01, 1'b0};
    vec[8]  = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b01, 1'b0};
    vec[9]  = '{8'h52, 1'b1, 1, 0, 0, 0, 0, 8'h52, 2'b01, 1'b0};
    vec[10] = '{8'h0D, 1'b1, 1, 0, 0, 1, 0, 8'h0D, 2'b10, 1'b0};
    vec[11] = '{8'h70, 1'b1, 1, 0, 1, 0, 0, 8'h70, 2'b10, 1'b0};
    vec[12] = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b10, 1'b0};
    vec[13] = '{8'h50, 1'b1, 1, 0, 0, 0, 0, 8'h50, 2'b10, 1'b0};
    vec[14] = '{8'h58, 1'b1, 1, 0, 1, 0, 0, 8'h58, 2'b10, 1'b0};
    vec[15] = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b10, 1'b0};
    vec[16] = '{8'h0A, 1'b1, 1, 0, 0, 0, 0, 8'h0A, 2'b10, 1'b0};
    vec[17] = '{8'h46, 1'b1, 1, 0, 0, 0, 0, 8'h46, 2'b10, 1'b0};
    vec[18] = '{8'h0D, 1'b1, 1, 0, 0, 0, 1, 8'h0D, 2'b10, 1'b1};
    vec[19] = '{8'h4C, 1'b1, 1, 0, 0, 0, 0, 8'h4C, 2'b10, 1'b1};
    vec[20] = '{8'h0A, 1'b1, 1, 0, 1, 0, 0, 8'h0A, 2'b10, 1'b1};
    vec[21] = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b10, 1'b1};
    vec[22] = '{8'h42, 1'b1, 1, 0, 0, 0, 0, 8'h42, 2'b10, 1'b1};
    vec[23] = '{8'h0D, 1'b1, 1, 0, 0, 0, 1, 8'h0D, 2'b10, 1'b0};
    vec[24] = '{8'h53, 1'b1, 1, 0, 0, 0, 0, 8'h53, 2'b10, 1'b0};
    vec[25] = '{8'h55, 1'b0, 0, 1, 1, 0, 0, 8'h53, 2'b10, 1'b0};
    vec[26] = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b10, 1'b0};
    vec[27] = '{8'h51, 1'b1, 1, 0, 1, 0, 0, 8'h51, 2'b10, 1'b0};
    vec[28] = '{8'hAA, 1'b0, 0, 1, 0, 0, 0, 8'h51, 2'b10, 1'b0};
    vec[29] = '{8'h0D, 1'b1, 1, 0, 0, 0, 0, 8'h0D, 2'b10, 1'b0};

    rst    = 1'b1;
    rxData = 1'b1;
    tick(4);
    check("reset_rxByte", int'(rxByte), 0);
    check("reset_rxValid", int'(rxValid), 0);
    check("reset_frameErr", int'(frameErr), 0);
    check("reset_dirCmd", int'(dirCmd), 3);
    check("reset_driveCmd", int'(driveCmd), 1);
    check("reset_strobes", int'({dirValid, driveValid, cmdErr}), 0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 30; i++) begin
      s_rx = rx_n; s_ferr = ferr_n; s_cerr = cerr_n; s_dir = dir_n; s_drv = drv_n;
      send_byte(vec[i].b, vec[i].stop);
      check($sformatf("row%0d_rxValid", i), rx_n - s_rx, vec[i].rx);
      check($sformatf("row%0d_frameErr", i), ferr_n - s_ferr, vec[i].ferr);
      check($sformatf("row%0d_cmdErr", i), cerr_n - s_cerr, vec[i].cerr);
      check($sformatf("row%0d_dirValid", i), dir_n - s_dir, vec[i].dir);
      check($sformatf("row%0d_driveValid", i), drv_n - s_drv, vec[i].drv);
      check($sformatf("row%0d_rxByte", i), int'(rxByte), int'(vec[i].exp_byte));
      check($sformatf("row%0d_dirCmd", i), int'(dirCmd), int'(vec[i].exp_dc));
      check($sformatf("row%0d_driveCmd", i), int'(driveCmd), int'(vec[i].exp_dr));
    end

    // Glitch while parser holds a pending 'P': no strobes, pending command survives
    send_byte(8'h50, 1'b1);
    s_rx = rx_n; s_ferr = ferr_n; s_cerr = cerr_n; s_dir = dir_n;
    rxData = 1'b0;
    tick(6);
    rxData = 1'b1;
    tick(40);
    check("glitch_rxValid", rx_n - s_rx, 0);
    check("glitch_frameErr", ferr_n - s_ferr, 0);
    check("glitch_cmdErr", cerr_n - s_cerr, 0);
    send_byte(8'h0D, 1'b1);
    check("glitch_then_cr_dirValid", dir_n - s_dir, 1);
    check("glitch_then_cr_dirCmd", int'(dirCmd), 0);

    // Reset in the middle of bit 4 of 'P'
    s_rx = rx_n; s_ferr = ferr_n; s_dir = dir_n;
    pframe = {1'b1, 8'h50, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxData = pframe[i];
      tick(CPB);
    end
    rxData = pframe[5];
    tick(CPB / 2);
    rst    = 1'b1;
    rxData = 1'b1;
    tick(2);
    check("midreset_rxByte", int'(rxByte), 0);
    check("midreset_dirCmd", int'(dirCmd), 3);
    check("midreset_driveCmd", int'(driveCmd), 1);
    check("midreset_strobes", int'({rxValid, frameErr, dirValid, driveValid, cmdErr}), 0);
    rst = 1'b0;
    tick(200);
    check("midreset_no_rxValid", rx_n - s_rx, 0);
    check("midreset_no_frameErr", ferr_n - s_ferr, 0);
    send_byte(8'h50, 1'b1);
    send_byte(8'h0D, 1'b1);
    check("after_reset_dirValid", dir_n - s_dir, 1);
    check("after_reset_dirCmd", int'(dirCmd), 0);

`ifdef UART_RX_ECHO_EN
    echo_q.delete();
    s_drv = drv_n;
    send_byte(8'h46, 1'b1);
    send_byte(8'h0D, 1'b1);
    check("echo_count", echo_q.size(), 2);
    if (echo_q.size() >= 2) begin
      check("echo_byte0", int'(echo_q[0]), 8'h46);
      check("echo_byte1", int'(echo_q[1]), 8'h0D);
    end
    check("echo_driveValid", drv_n - s_drv, 1);
`endif

    check("dir_and_drive_same_cycle", int'(both_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Serial command receiver for the robot's UART link; mirrors the status transmitter and its message FIFO path.
- Receives 8N1 bytes from the host terminal and parses single-letter commands terminated by CR.
- Issues direction and drive-mode commands to the drive controller as one-cycle strobes.
- Sits beside the UART transmit path on the system clock.

Parameters:
- CLKS_PER_BIT, 5208: system clocks per bit (50 MHz / 9600 baud). Minimum 4.
- CNT_W, 13: width of the bit-period counter. Must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rxData  in  1  asynchronous serial input; idles high.
- rxByte  out  8  last received data byte.
- rxValid  out  1  one-cycle strobe; rxByte is new.
- frameErr  out  1  one-cycle strobe; stop bit sampled low.
- dirCmd  out  2  latched direction code (DC_* encoding).
- dirValid  out  1  one-cycle strobe on dirCmd update.
- driveCmd  out  1  latched drive direction (FORWARDS/REVERSE).
- driveValid  out  1  one-cycle strobe on driveCmd update.
- cmdErr  out  1  one-cycle strobe on malformed or unknown command.
- echoDin  out  8  echo byte. Present only with UART_RX_ECHO_EN.
- echoWrEn  out  1  echo write strobe. Present only with UART_RX_ECHO_EN.

Behaviour:
- Reset values:
  - All strobes 0.
  - rxByte 0.
  - dirCmd DC_STOP.
  - driveCmd FORWARDS.
  - Both FSMs in their idle states.
  - Synchronizer flops preset to 1.
- Input path: rxData passes through a 2-flop synchronizer. Call the synchronized signal rxS.
- Receiver FSM: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: when rxS is 0, clear the counter and go to RX_START.
  - RX_START: at count CLKS_PER_BIT/2 (integer division), sample rxS.
    - 0: go to RX_DATA.
    - 1: glitch; return to RX_IDLE with no strobe.
  - RX_DATA: sample every CLKS_PER_BIT clocks after the start midpoint. Shift in LSB first, 8 bits, then go to RX_STOP.
  - RX_STOP: sample once, one bit period later.
    - 1: rxByte <= shifted byte; pulse rxValid the next cycle.
    - 0: pulse frameErr; rxByte is unchanged; no rxValid.
    - Either case: return to RX_IDLE. A new start may be detected from the cycle after the stop sample.
- Latency: rxValid asserts 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the rxData falling edge, within ±1.
- Parser FSM: P_WAIT, P_TERM, P_DISCARD. It advances only on rxValid or frameErr.
- P_WAIT:
  - 'P','L','R','S' → store as a direction command; go to P_TERM.
  - 'F','B' → store as a drive command; go to P_TERM.
  - CR (13) or LF (10) → ignore; stay in P_WAIT.
  - Any other byte → pulse cmdErr; go to P_DISCARD.
- P_TERM:
  - CR → commit the stored command; go to P_WAIT.
    - 'P','L','R','S' set dirCmd to DC_PROCEED, DC_TURN_LEFT, DC_TURN_RIGHT, DC_STOP respectively, with dirValid.
    - 'F' sets driveCmd to FORWARDS with driveValid; 'B' sets REVERSE with driveValid.
    - Outputs and strobe change the cycle after the CR rxValid.
  - Any other byte → pulse cmdErr; go to P_DISCARD.
- P_DISCARD: consume bytes until CR, then go to P_WAIT. No further cmdErr pulses.
- frameErr in P_WAIT or P_TERM: pulse cmdErr (same cycle as frameErr), drop the stored command, go to P_DISCARD. frameErr in P_DISCARD: no cmdErr.
- Commands are case-sensitive; lowercase letters are errors.
- dirValid and driveValid never assert in the same cycle.
- Reset mid-frame aborts reception and parsing. A partially received byte is lost with no strobe.

Optional Feature:
- Macro: UART_RX_ECHO_EN.
- Defined: echoWrEn pulses with every rxValid and echoDin = rxByte. The system feeds these into the transmit buffer write port so the terminal sees typed characters. The TX FIFO full case is ignored; the byte is dropped.
- Undefined: echoDin and echoWrEn ports are absent and no echo logic is built.

Decomposition:
- parameters.vh holds these constants:
  - DC_PROCEED=2'b00, DC_TURN_LEFT=2'b01, DC_TURN_RIGHT=2'b10, DC_STOP=2'b11.
  - FORWARDS=1'b1, REVERSE=1'b0.
  - ASCII_CR=13, ASCII_LF=10.
  - RX_* and P_* state encodings.
- Sub-module uart_rx_byte contains the synchronizer, the bit counter and the receiver FSM; outputs rxByte, rxValid, frameErr.
- uart_cmd_rx instantiates it and implements the parser.

Test Plan (CLKS_PER_BIT=16):
- Send 0x41 ('A'), correct stop bit → rxValid once, rxByte=0x41, cmdErr=1, no dirValid; then CR → no cmdErr, no dirValid.
- Send "L",CR → dirValid once with dirCmd=2'b01; after "B",CR → driveValid once with driveCmd=0.
- Send 0x55 with stop bit held low → frameErr once, no rxValid, cmdErr once; following "S",CR ignored until CR, next "R",CR → dirCmd=2'b10.
- 6-clock low pulse on idle rxData → no rxValid, no frameErr, parser state unchanged.
- Assert rst during bit 4 of 'P' → all outputs at reset values, dirCmd=2'b11; subsequent "P",CR → dirCmd=2'b00.
- UART_RX_ECHO_EN defined, send "F",CR → echoWrEn pulses twice with echoDin=0x46 then 0x0D; driveValid once.
